// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, control-word layout and bus constants shared by the PWM peripheral.
package pwm_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_PERIOD   = 5'h08;
    localparam logic [4:0] OFF_DUTY0    = 5'h0C;
    localparam logic [4:0] OFF_DUTY1    = 5'h10;
    localparam logic [4:0] OFF_DUTY2    = 5'h14;
    localparam logic [4:0] OFF_DUTY3    = 5'h18;
    localparam logic [4:0] OFF_STATUS   = 5'h1C;

    localparam int CTRL_EN_LSB  = 0;
    localparam int CTRL_GEN_BIT = 4;
    localparam int CTRL_INV_BIT = 5;
    localparam int CTRL_W       = 6;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef struct packed {
        logic       invert;
        logic       gen;
        logic [3:0] en;
    } ctrl_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one compare stage; output is registered so it lags the counter by one cycle.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty_sh,
    input  logic             en,
    input  logic             gen,
    input  logic             invert,
    output logic             pwm
);

    logic pwm_q, pwm_d;

    always_comb pwm_d = (en && gen && cnt < duty_sh) ^ invert;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_rgb_periph.sv
// pwm_rgb_periph: memory-mapped 4-channel PWM; period and duties are shadowed and
// only swapped in at the period wrap so software writes never glitch a running pulse.
module pwm_rgb_periph
    import pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          CNT_W     = 16,
    parameter int          PRE_W     = 16,
    parameter int          NCH       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           write_mem,
    input  logic [2:0]     funct3,
    input  logic [31:0]    address,
    input  logic [31:0]    write_data,
    output logic           hit,
    output logic [31:0]    read_data,
    output logic [NCH-1:0] pwm,
    output logic           period_tick
);

    logic [31:0]      off;
    logic [4:0]       woff;
    logic             we;
    logic             tick;
    logic             wrap;
    logic             unused_bits;
    ctrl_t            ctrl_q, ctrl_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] period_sh_q, period_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q [NCH];
    logic [CNT_W-1:0] duty_d [NCH];
    logic [CNT_W-1:0] duty_sh_q [NCH];
    logic [CNT_W-1:0] duty_sh_d [NCH];
    logic [31:0]      rd_mux;
    logic [31:0]      read_data_q, read_data_d;

    // Unsigned offset: anything below the base wraps to a huge value and misses.
    assign off         = address - BASE_ADDR;
    assign hit         = off < 32'd32;
    assign woff        = {off[4:2], 2'b00};
    assign we          = write_mem && hit && funct3 == FUNCT3_WORD;
    assign tick        = ctrl_q.gen && pre_cnt_q == prescale_q;
    assign wrap        = tick && cnt_q == period_sh_q;
    assign period_tick = wrap;
    assign read_data   = read_data_q;
    assign unused_bits = ^write_data[31:CNT_W];

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        duty_d     = duty_q;
        if (we && woff == OFF_CTRL) begin
            ctrl_d.en     = write_data[CTRL_EN_LSB +: 4];
            ctrl_d.gen    = write_data[CTRL_GEN_BIT];
            ctrl_d.invert = write_data[CTRL_INV_BIT];
        end
        if (we && woff == OFF_PRESCALE) prescale_d = write_data[PRE_W-1:0];
        if (we && woff == OFF_PERIOD)   period_d   = write_data[CNT_W-1:0];
        for (int i = 0; i < NCH; i++)
            if (we && woff == OFF_DUTY0 + 5'(4 * i)) duty_d[i] = write_data[CNT_W-1:0];
    end

    // Shadows follow the live registers while stopped, so enabling starts with current values.
    always_comb begin
        pre_cnt_d   = (!ctrl_q.gen || tick) ? '0 : pre_cnt_q + 1'b1;
        cnt_d       = (!ctrl_q.gen || wrap) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
        period_sh_d = (!ctrl_q.gen || wrap) ? period_q : period_sh_q;
        for (int i = 0; i < NCH; i++)
            duty_sh_d[i] = (!ctrl_q.gen || wrap) ? duty_q[i] : duty_sh_q[i];
    end

    always_comb begin
        rd_mux = '0;
        case (off[4:2])
            OFF_CTRL[4:2]:     rd_mux[CTRL_W-1:0] = ctrl_q;
            OFF_PRESCALE[4:2]: rd_mux[PRE_W-1:0]  = prescale_q;
            OFF_PERIOD[4:2]:   rd_mux[CNT_W-1:0]  = period_q;
            OFF_DUTY0[4:2]:    rd_mux[CNT_W-1:0]  = duty_q[0];
            OFF_DUTY1[4:2]:    rd_mux[CNT_W-1:0]  = duty_q[1];
            OFF_DUTY2[4:2]:    rd_mux[CNT_W-1:0]  = duty_q[2];
            OFF_DUTY3[4:2]:    rd_mux[CNT_W-1:0]  = duty_q[3];
            OFF_STATUS[4:2]: begin
                rd_mux[CNT_W-1:0] = cnt_q;
                rd_mux[31]        = ctrl_q.gen;
            end
            default:           rd_mux = '0;
        endcase
        read_data_d = hit ? rd_mux : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            pre_cnt_q   <= '0;
            period_q    <= '0;
            period_sh_q <= '0;
            cnt_q       <= '0;
            read_data_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]    <= '0;
                duty_sh_q[i] <= '0;
            end
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            pre_cnt_q   <= pre_cnt_d;
            period_q    <= period_d;
            period_sh_q <= period_sh_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            duty_q      <= duty_d;
            duty_sh_q   <= duty_sh_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .cnt     (cnt_q),
            .duty_sh (duty_sh_q[c]),
            .en      (ctrl_q.en[c]),
            .gen     (ctrl_q.gen),
            .invert  (ctrl_q.invert),
            .pwm     (pwm[c])
        );
    end

endmodule

// File: tb/tb_pwm_rgb_periph.sv
// tb_pwm_rgb_periph: directed waveform checks plus randomized bus traffic scored
// cycle by cycle against a register-map level model of the peripheral.
module tb_pwm_rgb_periph;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;
    logic [3:0]  pwm;
    logic        period_tick;

    int errors = 0;
    int checks = 0;

    // model: the eight words as software sees them, plus timing state
    logic [31:0] m_reg [8];
    logic [15:0] m_pre, m_cnt, m_psh;
    logic [15:0] m_dsh [4];
    logic [3:0]  m_pwm;
    logic [31:0] m_rd;

    int hi_n [4];
    int tk_n;

    pwm_rgb_periph dut (
        .clk         (clk),
        .reset       (reset),
        .write_mem   (write_mem),
        .funct3      (funct3),
        .address     (address),
        .write_data  (write_data),
        .hit         (hit),
        .read_data   (read_data),
        .pwm         (pwm),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return a >= BASE && a <= BASE + 32'd31;
    endfunction

    function automatic logic m_ptick();
        return m_reg[0][4] && m_pre == m_reg[1][15:0] && m_cnt == m_psh;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        for (int i = 0; i < 4; i++) m_dsh[i] = '0;
        m_pre = '0; m_cnt = '0; m_psh = '0; m_pwm = '0; m_rd = '0;
    endtask

    // One clock of the peripheral's rules, evaluated on pre-edge state.
    task automatic model_step();
        logic        gen, tick, wrap;
        logic [3:0]  np;
        logic [31:0] nrd;
        int          w;
        gen  = m_reg[0][4];
        tick = gen && m_pre == m_reg[1][15:0];
        wrap = tick && m_cnt == m_psh;
        for (int i = 0; i < 4; i++)
            np[i] = (m_reg[0][i] && gen && m_cnt < m_dsh[i]) ^ m_reg[0][5];
        w   = 0;
        nrd = '0;
        if (m_hit(address)) begin
            w   = int'((address - BASE) >> 2);
            nrd = (w == 7) ? {gen, 15'd0, m_cnt} : m_reg[w];
        end
        if (!gen || wrap) begin
            m_psh = m_reg[2][15:0];
            for (int i = 0; i < 4; i++) m_dsh[i] = m_reg[3 + i][15:0];
        end
        m_pre = (gen && !tick) ? m_pre + 16'd1 : 16'd0;
        m_cnt = (!gen || wrap) ? 16'd0 : m_cnt + 16'(tick);
        if (write_mem && m_hit(address) && funct3 == 3'b010 && w != 7)
            m_reg[w] = write_data & ((w == 0) ? 32'h3F : 32'hFFFF);
        m_pwm = np;
        m_rd  = nrd;
    endtask

    task automatic cycle();
        @(negedge clk);
        check("pwm", {28'd0, pwm}, {28'd0, m_pwm});
        check("period_tick", {31'd0, period_tick}, {31'd0, m_ptick()});
        check("hit", {31'd0, hit}, {31'd0, m_hit(address)});
        check("read_data", read_data, m_rd);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        address    = BASE + {27'd0, o};
        write_data = d;
        funct3     = 3'b010;
        write_mem  = 1'b1;
        cycle();
        write_mem  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < 4; i++) hi_n[i] = 0;
        tk_n = 0;
        repeat (n) begin
            cycle();
            for (int i = 0; i < 4; i++) hi_n[i] += int'(pwm[i]);
            tk_n += int'(period_tick);
        end
    endtask

    initial begin
        int k, h0;
        logic [31:0] r, d;
        logic [4:0]  o;
        reset = 1'b1; write_mem = 1'b0; funct3 = 3'b010; address = '0; write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm", {28'd0, pwm}, 32'd0);
        check("rst_ptick", {31'd0, period_tick}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            address = BASE + 32'(4 * i);
            cycle();
            check($sformatf("rd_off%0d", 4 * i), read_data, 32'd0);
        end

        // 10-clock period, 3 high
        wr(5'h04, 32'd0); wr(5'h08, 32'd9); wr(5'h10, 32'd3); wr(5'h00, 32'h12);
        run(5);
        run(30);
        check("d3_high", 32'(hi_n[1]), 32'd9);
        check("d3_ticks", 32'(tk_n), 32'd3);

        // mid-period duty change keeps the running pulse
        k = 0;
        while (period_tick !== 1'b1 && k < 50) begin cycle(); k++; end
        check("wait_tick", {31'd0, period_tick}, 32'd1);
        cycle();
        wr(5'h10, 32'd7);
        h0 = int'(pwm[1]);
        run(9);
        check("mid_cur", 32'(h0 + hi_n[1]), 32'd3);
        run(10);
        check("mid_next", 32'(hi_n[1]), 32'd7);
        check("mid_next_tick", 32'(tk_n), 32'd1);

        // duty 0 / duty > period, then inverted
        wr(5'h00, 32'h05); wr(5'h0C, 32'd0); wr(5'h14, 32'd20); wr(5'h00, 32'h15);
        run(2);
        run(20);
        check("duty0_off", 32'(hi_n[0]), 32'd0);
        check("duty20_on", 32'(hi_n[2]), 32'd20);
        wr(5'h00, 32'h35);
        run(2);
        run(20);
        check("inv_duty0", 32'(hi_n[0]), 32'd20);
        check("inv_duty20", 32'(hi_n[2]), 32'd0);

        // prescaled: 4 clk per count, 20 clk period, 8 high
        wr(5'h00, 32'h00); wr(5'h04, 32'd3); wr(5'h08, 32'd4); wr(5'h18, 32'd2); wr(5'h00, 32'h18);
        run(3);
        run(40);
        check("pre_high", 32'(hi_n[3]), 32'd16);
        check("pre_ticks", 32'(tk_n), 32'd2);

        // ignored writes and window edges
        address = BASE + 32'h08; write_data = 32'd7; funct3 = 3'b000; write_mem = 1'b1;
        cycle();
        write_mem = 1'b0; funct3 = 3'b010;
        cycle();
        check("byte_wr_ignored", read_data, 32'd4);
        address = BASE + 32'h20; write_data = 32'h0; write_mem = 1'b1;
        #1;
        check("hit_0x20", {31'd0, hit}, 32'd0);
        cycle();
        write_mem = 1'b0;
        address = BASE + 32'h1C;
        #1;
        check("hit_0x1c", {31'd0, hit}, 32'd1);
        address = BASE;
        cycle();
        check("ctrl_kept", read_data, 32'h18);

        // asynchronous reset mid-period
        wr(5'h00, 32'h38);
        run(7);
        reset = 1'b1;
        #1;
        check("arst_pwm", {28'd0, pwm}, 32'd0);
        check("arst_ptick", {31'd0, period_tick}, 32'd0);
        check("arst_rdata", read_data, 32'd0);
        model_reset();
        #1;
        reset = 1'b0;
        wr(5'h04, 32'd0); wr(5'h08, 32'd9); wr(5'h10, 32'd3); wr(5'h00, 32'h12);
        address = BASE + 32'h1C;
        cycle();
        check("restart_status", read_data, 32'h8000_0000);

        // randomized traffic against the model
        repeat (3000) begin
            r = $urandom;
            o = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) address = (r[0]) ? BASE + 32'd32 + 32'($urandom_range(0, 63)) : BASE - 32'($urandom_range(1, 64));
            else address = BASE + {27'd0, o};
            case (o[4:2])
                3'd0: d = {r[31:6], 1'b0, r[4:0]} | (($urandom_range(0, 7) != 0) ? 32'h10 : 32'h0);
                3'd1: d = {r[31:16], 16'd1};
                3'd2: d = {r[31:16], 16'($urandom_range(0, 12))};
                default: d = {r[31:16], 16'($urandom_range(0, 15))};
            endcase
            write_data = d;
            write_mem  = ($urandom_range(0, 5) == 0);
            funct3     = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            cycle();
        end
        write_mem = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_rgb_periph.md
Name: pwm_rgb_periph

Overview:
- Memory-mapped PWM peripheral downstream of the multicycle core's data bus; snoops the same address/write-data/write-strobe the memory block sees.
- Turns software-written period/duty registers into four glitch-free PWM outputs (led, red, green, blue).
- Duty/period are double-buffered: they take effect only at a period boundary.
- The top-level read mux selects read_data when hit=1.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 32-byte register window
CNT_W, 16, width of period, duty and main counter
PRE_W, 16, width of prescaler register and counter
NCH, 4, number of PWM channels (fixed at 4 by the register map)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
write_mem  input  1  core store strobe
funct3  input  3  store width; only 3'b010 (word) writes are accepted
address  input  32  shared read/write byte address
write_data  input  32  store data
hit  output  1  combinational: address falls in [BASE_ADDR, BASE_ADDR+0x1F]
read_data  output  32  registered read data
pwm  output  NCH  PWM outputs, bit0=led, 1=red, 2=green, 3=blue
period_tick  output  1  one-cycle pulse at each period wrap

Behaviour:
- Register map (byte offsets, word access only):
  - 0x00 CTRL: [3:0] channel enable; [4] global enable GEN; [5] invert polarity.
  - 0x04 PRESCALE [PRE_W-1:0].
  - 0x08 PERIOD [CNT_W-1:0].
  - 0x0C/0x10/0x14/0x18 DUTY0..3.
  - 0x1C STATUS (read-only): [CNT_W-1:0] live counter; [31] GEN.
- Writes:
  - Accepted on the clk edge when write_mem && hit && funct3==3'b010.
  - Upper unused bits are discarded.
  - Writes to STATUS, sub-word writes and out-of-window writes are ignored.
- Reads:
  - read_data updates every cycle from the address registered that cycle: one-cycle latency, zero-extended.
  - read_data is 0 when not hit.
- Reset: all registers, shadows, counters, read_data, pwm and period_tick go to 0 asynchronously. Reset asserted mid-period aborts the period immediately, with no completion.
- Prescaler:
  - pre_cnt counts 0..PRESCALE.
  - tick=1 when pre_cnt==PRESCALE, then pre_cnt returns to 0.
  - PRESCALE=0 gives tick every cycle.
- Main counter:
  - On tick, cnt increments; if cnt==period_sh it wraps to 0 instead.
  - The wrap cycle asserts period_tick for exactly one clk and loads period_sh and duty_sh[i] from the active registers.
- Compare:
  - raw[i] = CTRL.en[i] && GEN && (cnt < duty_sh[i]).
  - pwm[i] = raw[i] XOR CTRL.invert, registered: one-cycle latency after cnt.
  - Duty 0 gives constant inactive; duty > period gives constant active.
  - PERIOD=0: cnt held at 0, period_tick on every tick.
- GEN=0:
  - pre_cnt and cnt held at 0; period_tick=0.
  - Shadows track the active registers every cycle.
  - pwm[i] = invert (inactive level).
- GEN 0→1: counting starts from 0 on the following cycle, using the current register values.
- Write coinciding with the wrap cycle: the shadow captures the pre-write value; the new value applies from the next period.
- A mid-period write to DUTY or PERIOD never alters the current period's waveform.

Decomposition:
- pwm_pkg:
  - Register offset localparams (OFF_CTRL, OFF_PRESCALE, OFF_PERIOD, OFF_DUTY0..3, OFF_STATUS).
  - CTRL bit positions and the FUNCT3_WORD constant.
  - A ctrl_t packed struct.
- Sub-module pwm_channel, instantiated NCH times:
  - Inputs: cnt, duty_sh, en, gen, invert.
  - Owns the compare and the registered output.
- Top holds bus decode, registers, prescaler, counter and shadow logic.

Test Plan:
- Reset, then read all 8 offsets → 0 one cycle after each address; pwm=0, period_tick=0.
- PRESCALE=0, PERIOD=9, DUTY1=3, CTRL=0x12 → pwm[1] high 3 cycles, low 7, repeating every 10 clk; period_tick every 10th clk.
- Mid-period write DUTY1=7 → current period keeps a 3-high pulse; next period is 7 high / 3 low.
- DUTY0=0 and DUTY2=20 with PERIOD=9, CTRL=0x15 → pwm[0] constantly 0, pwm[2] constantly 1; with invert (CTRL=0x35), both flip.
- PRESCALE=3, PERIOD=4, DUTY3=2 → pwm[3] high 8 clk out of 20.
- Byte write (funct3=000) to PERIOD, and a write to BASE_ADDR+0x20 → no register change, hit=0 for the latter; assert reset mid-period → all outputs 0 immediately; after release, restart from cnt=0.
